fd_stage_reg: RTL and testbench
===============================

Name: fd_stage_reg

Overview:
- Parametrised fetch/decode pipeline register: the next generation of the team's F/D latch.
- Carries PC and instruction from fetch to decode.
- Inserts NOP bubbles on control-transfer requests and holds a programmable squash window after taken jumps.
- Adds stall/hold, an explicit flush, a valid flag and a saturating bubble counter for performance monitoring.

Parameters:
- PC_W, 32, PC width in bits.
- INS_W, 32, instruction width in bits.
- NOP_INS, 32'hdc000000, bubble encoding driven on ins_out when squashed (INS_W bits).
- SQUASH_CYCLES, 2, cycles of squash after a taken jump, excluding the request cycle; 0 disables the window; legal range 0..15.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstd  in  1  reset; asynchronous, active-low.
- stall  in  1  hold current contents; no load.
- flush  in  1  unconditional single-cycle bubble, e.g. exception or redirect.
- jon_d  in  2  jump request from decode; any nonzero value = bubble this cycle; bit1 = taken jump, which starts the squash window.
- pc_in  in  PC_W  fetched PC.
- ins_in  in  INS_W  fetched instruction.
- pc_out  out  PC_W  registered PC.
- ins_out  out  INS_W  registered instruction or NOP_INS.
- valid_out  out  1  1 = ins_out is a real instruction; 0 = bubble.
- squash_active  out  1  squash counter nonzero.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted since reset.
- bubble_clr  in  1  synchronous clear of bubble_cnt.

Behaviour:
- Reset (rstd=0, async): ins_out=NOP_INS, pc_out=0, valid_out=0, squash counter=0, bubble_cnt=0.
- Definition: kill = flush | (jon_d!=0) | (squash counter>0), sampled in the same cycle.
- Per-edge priority is reset > kill > stall > load:
  - kill: ins_out<=NOP_INS, valid_out<=0, pc_out holds. Kill applies even while stall=1, so a redirect is never lost.
  - stall (no kill): all data registers hold.
  - else load: pc_out<=pc_in, ins_out<=ins_in, valid_out<=1.
- Latency: one cycle from pc_in/ins_in to outputs.
- Squash counter, 4 bits, updated on the same edge as the data registers:
  - jon_d[1]=1 → load SQUASH_CYCLES, regardless of stall or current value (a new jump restarts the window).
  - else if counter>0 and stall=0 → decrement.
  - Stall freezes the window, because fetch is frozen too.
- Example: SQUASH_CYCLES=2, jon_d=2'b10 for one cycle, no stall → exactly 3 consecutive bubbles (request cycle plus 2).
- jon_d=2'b01: one bubble only; the counter is not loaded.
- bubble_cnt:
  - Increments by 1 on each edge where kill=1; stalls without kill do not count.
  - Saturates at all-ones; never wraps.
  - bubble_clr=1 → 0 on the next edge. If kill occurs in the same cycle, clear wins and the result is 0.
- squash_active = (counter!=0), combinational from the register.
- Reset asserted mid-window: counter and outputs clear immediately. After rstd rises, the first edge loads normally.

Test Plan:
- Reset then load: rstd 0→1, stall=0, flush=0, jon_d=0, pc_in=0x100, ins_in=0x12345678 → after 1 edge pc_out=0x100, ins_out=0x12345678, valid_out=1. During reset ins_out=0xdc000000, valid_out=0.
- Taken jump window: jon_d=2'b10 for one cycle, stream ins_in=A,B,C,D → ins_out = NOP, NOP, NOP, then D. squash_active high for 2 cycles. bubble_cnt=3.
- Stall during window: jon_d=2'b10, then stall=1 for 3 cycles → counter holds at 2 during the stall; ins_out stays NOP; after stall drops, 2 more bubbles, then a normal load.
- Stall vs flush: stall=1 holding ins_out=0xAAAA0000, flush=1 for one cycle → ins_out=0xdc000000, valid_out=0. Remaining stall cycles hold the NOP.
- Back-to-back jumps: jon_d=2'b10 at cycles 0 and 1 → window restarts, giving 4 consecutive bubbles total (cycles 0–3).
- Counter saturation and clear: CNT_W=4, force 20 flushes → bubble_cnt=15. Then bubble_clr=1 with flush=1 in the same cycle → bubble_cnt=0.

Source files
------------

// File: rtl/fd_stage_reg.sv
// Fetch/decode pipeline register: carries PC and instruction into decode, inserts
// NOP bubbles on flush/jump, holds a squash window after taken jumps, counts bubbles.
module fd_stage_reg #(
  parameter int                 PC_W          = 32,
  parameter int                 INS_W         = 32,
  parameter logic [INS_W-1:0]   NOP_INS       = 32'hdc000000,
  parameter int                 SQUASH_CYCLES = 2,
  parameter int                 CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       jon_d,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [INS_W-1:0] ins_in,
  output logic [PC_W-1:0]  pc_out,
  output logic [INS_W-1:0] ins_out,
  output logic             valid_out,
  output logic             squash_active,
  output logic [CNT_W-1:0] bubble_cnt,
  input  logic             bubble_clr
);

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

  logic [PC_W-1:0]  pc_p1;
  logic [INS_W-1:0] ins_p1;
  logic             vld_p1;
  logic [3:0]       sq_cnt_p1;
  logic [CNT_W-1:0] bub_cnt_p1;
  logic             kill_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: decide whether this edge inserts a bubble.
  assign kill_p0 = flush | (|jon_d) | (sq_cnt_p1 != 4'd0);

  // Stage p1: F/D register; a kill overrides stall so redirects are never lost.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      pc_p1      <= '0;
      ins_p1     <= NOP_INS;
      vld_p1     <= 1'b0;
      sq_cnt_p1  <= 4'd0;
      bub_cnt_p1 <= '0;
    end else begin
      if (kill_p0) begin
        ins_p1 <= NOP_INS;
        vld_p1 <= 1'b0;
      end else if (!stall) begin
        pc_p1  <= pc_in;
        ins_p1 <= ins_in;
        vld_p1 <= 1'b1;
      end

      // Window freezes under stall because fetch is frozen too.
      if (jon_d[1])
        sq_cnt_p1 <= SQ_LOAD;
      else if ((sq_cnt_p1 != 4'd0) && !stall)
        sq_cnt_p1 <= sq_cnt_p1 - 4'd1;

      if (bubble_clr)
        bub_cnt_p1 <= '0;
      else if (kill_p0)
        bub_cnt_p1 <= sat_inc(bub_cnt_p1);
    end
  end

  assign pc_out        = pc_p1;
  assign ins_out       = ins_p1;
  assign valid_out     = vld_p1;
  assign squash_active = (sq_cnt_p1 != 4'd0);
  assign bubble_cnt    = bub_cnt_p1;

endmodule

// File: tb/tb_fd_stage_reg.sv
// Directed bench for fd_stage_reg: reset, squash window, stall/flush interaction,
// back-to-back jumps, async reset mid-window and bubble counter saturation/clear.
module tb_fd_stage_reg;

  localparam logic [31:0] NOP = 32'hdc000000;

  logic        clk = 1'b0;
  logic        rstd;
  logic        stall, flush, bubble_clr;
  logic [1:0]  jon_d;
  logic [31:0] pc_in, ins_in;
  logic [31:0] pc_out, ins_out;
  logic        valid_out, squash_active;
  logic [3:0]  bubble_cnt;

  int tests_run = 0;
  int fails = 0;

  fd_stage_reg #(
    .PC_W(32), .INS_W(32), .NOP_INS(32'hdc000000), .SQUASH_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rstd(rstd), .stall(stall), .flush(flush), .jon_d(jon_d),
    .pc_in(pc_in), .ins_in(ins_in), .pc_out(pc_out), .ins_out(ins_out),
    .valid_out(valid_out), .squash_active(squash_active),
    .bubble_cnt(bubble_cnt), .bubble_clr(bubble_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    bubble_clr = 1'b1;
    step();
    bubble_clr = 1'b0;
  endtask

  task automatic test_reset();
    rstd = 1'b0; stall = 0; flush = 0; jon_d = 2'b00; bubble_clr = 0;
    pc_in = 32'h0; ins_in = 32'h0;
    #12;
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL rst_ins got %h exp %h", ins_out, NOP); end
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL rst_vld got %b exp 0", valid_out); end
    tests_run++; if (pc_out !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", pc_out); end
    tests_run++; if (squash_active !== 1'b0) begin fails++; $display("FAIL rst_sq got %b exp 0", squash_active); end
    tests_run++; if (bubble_cnt !== 4'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", bubble_cnt); end
    rstd = 1'b1;
    pc_in = 32'h100; ins_in = 32'h12345678;
    step();
    tests_run++; if (pc_out !== 32'h100) begin fails++; $display("FAIL load_pc got %h exp 100", pc_out); end
    tests_run++; if (ins_out !== 32'h12345678) begin fails++; $display("FAIL load_ins got %h exp 12345678", ins_out); end
    tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL load_vld got %b exp 1", valid_out); end
  endtask

  task automatic test_jump_window();
    do_clr();
    jon_d = 2'b10; pc_in = 32'h200; ins_in = 32'hA0000001;
    step();
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL win0_ins got %h exp %h", ins_out, NOP); end
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL win0_vld got %b exp 0", valid_out); end
    tests_run++; if (pc_out !== 32'h100) begin fails++; $display("FAIL win0_pc_hold got %h exp 100", pc_out); end
    tests_run++; if (squash_active !== 1'b1) begin fails++; $display("FAIL win0_sq got %b exp 1", squash_active); end
    jon_d = 2'b00; pc_in = 32'h204; ins_in = 32'hB0000002;
    step();
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL win1_ins got %h exp %h", ins_out, NOP); end
    tests_run++; if (squash_active !== 1'b1) begin fails++; $display("FAIL win1_sq got %b exp 1", squash_active); end
    pc_in = 32'h208; ins_in = 32'hC0000003;
    step();
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL win2_ins got %h exp %h", ins_out, NOP); end
    tests_run++; if (squash_active !== 1'b0) begin fails++; $display("FAIL win2_sq got %b exp 0", squash_active); end
    pc_in = 32'h20c; ins_in = 32'hD0000004;
    step();
    tests_run++; if (ins_out !== 32'hD0000004) begin fails++; $display("FAIL win3_ins got %h exp D0000004", ins_out); end
    tests_run++; if (pc_out !== 32'h20c) begin fails++; $display("FAIL win3_pc got %h exp 20c", pc_out); end
    tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL win3_vld got %b exp 1", valid_out); end
    tests_run++; if (bubble_cnt !== 4'd3) begin fails++; $display("FAIL win_cnt got %0d exp 3", bubble_cnt); end
  endtask

  task automatic test_stall_window();
    do_clr();
    jon_d = 2'b10; ins_in = 32'hE0000005; pc_in = 32'h2f0;
    step();
    jon_d = 2'b00; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL stwin_ins[%0d] got %h exp %h", i, ins_out, NOP); end
      tests_run++; if (squash_active !== 1'b1) begin fails++; $display("FAIL stwin_sq[%0d] got %b exp 1", i, squash_active); end
    end
    stall = 1'b0;
    step();
    tests_run++; if (squash_active !== 1'b1) begin fails++; $display("FAIL stwin_post1_sq got %b exp 1", squash_active); end
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL stwin_post1_ins got %h exp %h", ins_out, NOP); end
    step();
    tests_run++; if (squash_active !== 1'b0) begin fails++; $display("FAIL stwin_post2_sq got %b exp 0", squash_active); end
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL stwin_post2_ins got %h exp %h", ins_out, NOP); end
    pc_in = 32'h300; ins_in = 32'h11112222;
    step();
    tests_run++; if (ins_out !== 32'h11112222) begin fails++; $display("FAIL stwin_load got %h exp 11112222", ins_out); end
    tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL stwin_vld got %b exp 1", valid_out); end
    tests_run++; if (bubble_cnt !== 4'd6) begin fails++; $display("FAIL stwin_cnt got %0d exp 6", bubble_cnt); end
  endtask

  task automatic test_stall_flush();
    pc_in = 32'h400; ins_in = 32'hAAAA0000;
    step();
    stall = 1'b1; pc_in = 32'h404; ins_in = 32'hBBBB0000;
    step();
    tests_run++; if (ins_out !== 32'hAAAA0000) begin fails++; $display("FAIL stall_hold_ins got %h exp AAAA0000", ins_out); end
    tests_run++; if (pc_out !== 32'h400) begin fails++; $display("FAIL stall_hold_pc got %h exp 400", pc_out); end
    flush = 1'b1;
    step();
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL sflush_ins got %h exp %h", ins_out, NOP); end
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL sflush_vld got %b exp 0", valid_out); end
    tests_run++; if (pc_out !== 32'h400) begin fails++; $display("FAIL sflush_pc got %h exp 400", pc_out); end
    flush = 1'b0;
    step();
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL sflush_hold_ins got %h exp %h", ins_out, NOP); end
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL sflush_hold_vld got %b exp 0", valid_out); end
    stall = 1'b0;
    step();
    tests_run++; if (ins_out !== 32'hBBBB0000) begin fails++; $display("FAIL sflush_resume got %h exp BBBB0000", ins_out); end
    tests_run++; if (pc_out !== 32'h404) begin fails++; $display("FAIL sflush_resume_pc got %h exp 404", pc_out); end
  endtask

  task automatic test_back_to_back();
    do_clr();
    pc_in = 32'h500; ins_in = 32'hCCCC0000;
    jon_d = 2'b10;
    step();
    step();
    jon_d = 2'b00;
    tests_run++; if (squash_active !== 1'b1) begin fails++; $display("FAIL b2b_sq1 got %b exp 1", squash_active); end
    step();
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL b2b_c2 got %h exp %h", ins_out, NOP); end
    tests_run++; if (squash_active !== 1'b1) begin fails++; $display("FAIL b2b_sq2 got %b exp 1", squash_active); end
    step();
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL b2b_c3 got %h exp %h", ins_out, NOP); end
    step();
    tests_run++; if (ins_out !== 32'hCCCC0000) begin fails++; $display("FAIL b2b_load got %h exp CCCC0000", ins_out); end
    tests_run++; if (bubble_cnt !== 4'd4) begin fails++; $display("FAIL b2b_cnt got %0d exp 4", bubble_cnt); end
  endtask

  task automatic test_single_bubble();
    pc_in = 32'h580; ins_in = 32'h55550000;
    jon_d = 2'b01;
    step();
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL j01_ins got %h exp %h", ins_out, NOP); end
    tests_run++; if (squash_active !== 1'b0) begin fails++; $display("FAIL j01_sq got %b exp 0", squash_active); end
    jon_d = 2'b00;
    step();
    tests_run++; if (ins_out !== 32'h55550000) begin fails++; $display("FAIL j01_load got %h exp 55550000", ins_out); end
    tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL j01_vld got %b exp 1", valid_out); end
  endtask

  task automatic test_reset_mid_window();
    jon_d = 2'b10;
    step();
    jon_d = 2'b00;
    #2 rstd = 1'b0;
    #1;
    tests_run++; if (squash_active !== 1'b0) begin fails++; $display("FAIL mrst_sq got %b exp 0", squash_active); end
    tests_run++; if (ins_out !== NOP) begin fails++; $display("FAIL mrst_ins got %h exp %h", ins_out, NOP); end
    tests_run++; if (pc_out !== 32'h0) begin fails++; $display("FAIL mrst_pc got %h exp 0", pc_out); end
    tests_run++; if (bubble_cnt !== 4'd0) begin fails++; $display("FAIL mrst_cnt got %0d exp 0", bubble_cnt); end
    rstd = 1'b1;
    pc_in = 32'h600; ins_in = 32'h77770000;
    step();
    tests_run++; if (ins_out !== 32'h77770000) begin fails++; $display("FAIL mrst_load got %h exp 77770000", ins_out); end
    tests_run++; if (valid_out !== 1'b1) begin fails++; $display("FAIL mrst_vld got %b exp 1", valid_out); end
  endtask

  task automatic test_saturation();
    do_clr();
    flush = 1'b1;
    repeat (14) step();
    tests_run++; if (bubble_cnt !== 4'd14) begin fails++; $display("FAIL sat14 got %0d exp 14", bubble_cnt); end
    repeat (6) step();
    tests_run++; if (bubble_cnt !== 4'd15) begin fails++; $display("FAIL sat20 got %0d exp 15", bubble_cnt); end
    bubble_clr = 1'b1;
    step();
    tests_run++; if (bubble_cnt !== 4'd0) begin fails++; $display("FAIL clr_vs_kill got %0d exp 0", bubble_cnt); end
    bubble_clr = 1'b0; flush = 1'b0;
    step();
    tests_run++; if (bubble_cnt !== 4'd0) begin fails++; $display("FAIL clr_idle got %0d exp 0", bubble_cnt); end
  endtask

  initial begin
    test_reset();
    test_jump_window();
    test_stall_window();
    test_stall_flush();
    test_back_to_back();
    test_single_bubble();
    test_reset_mid_window();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
